// File: rtl/norm_sfp_row_seq.sv
// Row normaliser: takes COL signed psums, divides each |x_i| by S = sum|x_i| through one shared
// restoring divider, and emits FRAC-bit fixed-point ratios, optionally sign-preserving.

module norm_sfp_lane #(
    parameter int BW = 20
) (
    input  logic [BW-1:0] psum,
    output logic [BW-1:0] mag,
    output logic          neg
);
    // The most negative input maps to 2^(BW-1), which is exact when read as unsigned.
    assign neg = psum[BW-1];
    assign mag = neg ? (~psum) + BW'(1) : psum;
endmodule

module norm_sfp_row_seq #(
    parameter int COL     = 8,
    parameter int BW_PSUM = 20,
    parameter int FRAC    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sign_mode,
    input  logic [COL*BW_PSUM-1:0]   sfp_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*BW_PSUM-1:0]   sfp_out,
    output logic [BW_PSUM+$clog2(COL)-1:0] sum_out,
    output logic                     div_zero,
    output logic                     busy
);
    localparam int SW = BW_PSUM + $clog2(COL);
    localparam int RW = SW + 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int SC = $clog2(FRAC + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    typedef struct packed {
        logic [COL-1:0][BW_PSUM-1:0] mag;
        logic [COL-1:0]              neg;
        logic                        mode;
        logic [SW-1:0]               s;
    } row_t;

    state_t state, state_nxt;
    row_t   row;

    logic [COL-1:0][BW_PSUM-1:0] in_mag;
    logic [COL-1:0]              in_neg;
    logic [SW-1:0]               sum_in;
    logic [CW-1:0]               col;
    logic [SC-1:0]               step;
    logic [SW-1:0]               rem;
    logic [FRAC-1:0]             q;
    logic [RW-1:0]               cur, nrem;
    logic                        ge;
    logic [FRAC:0]               q_new;
    logic                        last_step, last_col;
    logic [COL-1:0][BW_PSUM-1:0] res;

    for (genvar i = 0; i < COL; i++) begin : g_lane
        norm_sfp_lane #(.BW(BW_PSUM)) u_lane (
            .psum (sfp_in[i*BW_PSUM +: BW_PSUM]),
            .mag  (in_mag[i]),
            .neg  (in_neg[i])
        );
    end

    always_comb begin
        sum_in = '0;
        for (int i = 0; i < COL; i++) sum_in = sum_in + SW'(in_mag[i]);
    end

    // One restoring-division step per cycle; step 0 loads |x_i| and yields the integer bit.
    assign cur       = (step == '0) ? RW'(row.mag[col]) : {rem, 1'b0};
    assign ge        = cur >= {1'b0, row.s};
    assign nrem      = ge ? cur - {1'b0, row.s} : cur;
    assign q_new     = {q, ge};
    assign last_step = step == SC'(FRAC);
    assign last_col  = col == CW'(COL - 1);

    // Finished quotients overwrite their magnitude slot, so the final row is assembled from row.mag.
    always_comb begin
        res = '0;
        for (int c = 0; c < COL; c++) begin
            res[c] = (CW'(c) == col) ? BW_PSUM'(q_new) : row.mag[c];
            if (row.mode && row.neg[c]) res[c] = '0 - res[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (sum_in == '0) ? DONE : DIV;
            DIV:     if (last_step && last_col) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row      <= '0;
            col      <= '0;
            step     <= '0;
            rem      <= '0;
            q        <= '0;
            sfp_out  <= '0;
            sum_out  <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    row.mag  <= in_mag;
                    row.neg  <= in_neg;
                    row.mode <= sign_mode;
                    row.s    <= sum_in;
                    col      <= '0;
                    step     <= '0;
                    if (sum_in == '0) begin
                        sfp_out  <= '0;
                        sum_out  <= '0;
                        div_zero <= 1'b1;
                    end
                end
                DIV: begin
                    rem <= SW'(nrem);
                    q   <= q_new[FRAC-1:0];
                    if (last_step) begin
                        row.mag[col] <= BW_PSUM'(q_new);
                        step         <= '0;
                        col          <= col + CW'(1);
                        if (last_col) begin
                            sfp_out  <= res;
                            sum_out  <= row.s;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        step <= step + SC'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_norm_sfp_row_seq.sv
// Directed and random rows against an arithmetic reference of the normalisation.

module tb_norm_sfp_row_seq;
    localparam int COL = 8, BW = 20, FRAC = 12, SW = BW + 3;
    localparam int LAT = COL * (FRAC + 1);

    logic clk = 1'b0, reset = 1'b0;
    logic in_valid = 1'b0, sign_mode = 1'b0, out_ready = 1'b0;
    logic [COL*BW-1:0] sfp_in = '0;
    logic in_ready, out_valid, div_zero, busy;
    logic [COL*BW-1:0] sfp_out;
    logic [SW-1:0] sum_out;

    int pass_cnt = 0, total = 0;

    norm_sfp_row_seq #(.COL(COL), .BW_PSUM(BW), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sign_mode(sign_mode), .sfp_in(sfp_in), .out_valid(out_valid),
        .out_ready(out_ready), .sfp_out(sfp_out), .sum_out(sum_out),
        .div_zero(div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [COL*BW-1:0] got, input logic [COL*BW-1:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic longint mabs(input logic [COL*BW-1:0] r, input int i);
        longint v;
        v = longint'($signed(r[i*BW +: BW]));
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint model_sum(input logic [COL*BW-1:0] r);
        longint s = 0;
        for (int i = 0; i < COL; i++) s += mabs(r, i);
        return s;
    endfunction

    function automatic logic [COL*BW-1:0] model_out(input logic [COL*BW-1:0] r, input logic mode);
        logic [COL*BW-1:0] o = '0;
        longint s = model_sum(r), qv;
        if (s == 0) return o;
        for (int i = 0; i < COL; i++) begin
            qv = (mabs(r, i) * (longint'(1) << FRAC)) / s;
            if (mode && $signed(r[i*BW +: BW]) < 0) qv = -qv;
            o[i*BW +: BW] = BW'(qv);
        end
        return o;
    endfunction

    // Called at posedge+1 with the block idle; returns at accept edge+1.
    task automatic start(input logic [COL*BW-1:0] r, input logic mode);
        sfp_in = r; sign_mode = mode; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int k = 0;
        while (!out_valid && k < 400) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, " latency"}, k, exp_lat);
    endtask

    task automatic chk_res(input string tag, input logic [COL*BW-1:0] r, input logic mode);
        chk({tag, " sfp_out"}, sfp_out, model_out(r, mode));
        chk({tag, " sum_out"}, sum_out, SW'(model_sum(r)));
        chk({tag, " div_zero"}, div_zero, model_sum(r) == 0);
    endtask

    task automatic handshake(input string tag);
        logic [COL*BW-1:0] held = sfp_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " idle flags"}, {out_valid, in_ready, busy}, 3'b010);
        chk({tag, " out held"}, sfp_out, held);
    endtask

    task automatic row_test(input string tag, input logic [COL*BW-1:0] r, input logic mode);
        start(r, mode);
        wait_out(tag, (model_sum(r) == 0) ? 0 : LAT);
        chk_res(tag, r, mode);
        handshake(tag);
    endtask

    logic [COL*BW-1:0] r1, r2, r3, r4, rz, ra, rb, rr;
    logic stable;

    initial begin
        r1 = '0; r2 = '0; r3 = '0; r4 = '0; rz = '0;
        for (int i = 0; i < COL; i++) r1[i*BW +: BW] = BW'(100);
        r2[0 +: BW] = BW'(-300); r2[BW +: BW] = BW'(100);
        r3[3*BW +: BW] = BW'(-524288);
        for (int i = 0; i < 3; i++) r4[i*BW +: BW] = BW'(1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset flags", {in_ready, out_valid, busy, div_zero}, 4'b1000);
        chk("reset sfp_out", sfp_out, '0);
        chk("reset sum_out", sum_out, '0);

        row_test("t1", r1, 1'b0);
        chk("t1 col0 const", sfp_out[0 +: BW], BW'(512));
        row_test("t2m1", r2, 1'b1);
        chk("t2 col0 const", sfp_out[0 +: BW], 20'hFF400);
        row_test("t2m0", r2, 1'b0);
        row_test("t3m0", r3, 1'b0);
        row_test("t3m1", r3, 1'b1);
        chk("t3 col3 const", sfp_out[3*BW +: BW], 20'hFF000);
        row_test("t4", r4, 1'b0);
        chk("t4 col1 const", sfp_out[BW +: BW], BW'(1365));
        row_test("zero", rz, 1'b1);

        // Stall in DONE; inputs offered meanwhile must be ignored.
        ra = '0; ra[0 +: BW] = BW'(7); ra[5 +: BW] = BW'(-9);
        rb = '0; rb[2*BW +: BW] = BW'(40); rb[6*BW +: BW] = BW'(-10);
        start(ra, 1'b1);
        wait_out("t5", LAT);
        chk_res("t5", ra, 1'b1);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sfp_in = rb; in_valid = c[0];
            @(posedge clk); #1;
            if (!out_valid || in_ready || sfp_out !== model_out(ra, 1'b1)) stable = 1'b0;
        end
        chk("t5 stable", stable, 1'b1);
        sfp_in = rb; sign_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5 post hs", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5 accepted", busy, 1'b1);
        wait_out("t5b", LAT);
        chk_res("t5b", rb, 1'b0);
        handshake("t5b");

        // Reset mid-divide aborts the row without publishing anything.
        start(r1, 1'b0);
        repeat (49) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t6 flags", {in_ready, out_valid, busy}, 3'b100);
        chk("t6 sfp_out", sfp_out, '0);
        row_test("t6 rerun", r1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rr = '0;
            for (int i = 0; i < COL; i++)
                rr[i*BW +: BW] = (n < 5) ? BW'($urandom) : BW'(int'($urandom_range(0, 2000)) - 1000);
            row_test("rand", rr, 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
